mips_regfile: RTL and testbench

MIPS_REGFILE -- requirements
Module: mips_regfile

---
 rtl/mips_regfile.sv | 93 +++++++++
 tb/tb_mips_regfile.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mips_regfile.sv
// mips_regfile: 2**ADDR_W x DATA_W register file with two registered read
// ports (A and B) and one write port, feeding the ALU operands a and b.
// Register 0 is hard-wired to zero; writes to it are dropped.
// Reads are strobed by rd_en and appear one cycle later with a_vld.
//
// Build option: define MIPS_REGFILE_BYPASS_EN for write-first behaviour
// when a read and a write hit the same nonzero address on the same edge.
// Leave it undefined for read-first (old contents returned).
module mips_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    input  logic              rd_en,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              a_vld
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];

    // Write qualifier: address 0 is never a write target.
    logic              wr_hit;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;

    // Read-stage output registers.
    logic [DATA_W-1:0] a_p1;
    logic [DATA_W-1:0] b_p1;
    logic              vld_p1;

    assign wr_hit = we && (wa_addr != '0);

    // Register array: reset clears every entry, otherwise accept qualified writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            regs[wa_addr] <= wd;
        end
    end

    // Read-data selection for both ports, with optional same-edge write forwarding.
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (ra_addr != '0) begin
            rdata_a = regs[ra_addr];
        end
        if (rb_addr != '0) begin
            rdata_b = regs[rb_addr];
        end
`ifdef MIPS_REGFILE_BYPASS_EN
        // wr_hit already excludes address 0, so r0 is never forwarded.
        if (wr_hit && (wa_addr == ra_addr)) begin
            rdata_a = wd;
        end
        if (wr_hit && (wa_addr == rb_addr)) begin
            rdata_b = wd;
        end
`endif
    end

    // Output stage: capture read data on rd_en, hold otherwise; reset wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_p1   <= '0;
            b_p1   <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_en;
            if (rd_en) begin
                a_p1 <= rdata_a;
                b_p1 <= rdata_b;
            end
        end
    end

    assign a     = a_p1;
    assign b     = b_p1;
    assign a_vld = vld_p1;

endmodule

// File: tb/tb_mips_regfile.sv
// tb_mips_regfile: directed-vector bench for mips_regfile. Expected values
// are hand-computed constants; the same-edge hazard expectation follows the
// MIPS_REGFILE_BYPASS_EN build option.
module tb_mips_regfile;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic [AW-1:0] ra_addr;
    logic [AW-1:0] rb_addr;
    logic          rd_en;
    logic          we;
    logic [AW-1:0] wa_addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          a_vld;

    int n_vec;
    int n_miscomp;

    mips_regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .ra_addr (ra_addr),
        .rb_addr (rb_addr),
        .rd_en   (rd_en),
        .we      (we),
        .wa_addr (wa_addr),
        .wd      (wd),
        .a       (a),
        .b       (b),
        .a_vld   (a_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscomp++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        we      = 1'b1;
        wa_addr = addr;
        wd      = data;
        step();
        we      = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        rd_en   = 1'b1;
        ra_addr = ra;
        rb_addr = rb;
        step();
        rd_en   = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] hazard_exp;
        n_vec     = 0;
        n_miscomp = 0;
        rst       = 1'b1;
        ra_addr   = '0;
        rb_addr   = '0;
        rd_en     = 1'b0;
        we        = 1'b0;
        wa_addr   = '0;
        wd        = '0;
        step();
        step();
        check("reset_a", a, 32'h0);
        check("reset_b", b, 32'h0);
        check("reset_vld", {31'b0, a_vld}, 32'h0);
        rst = 1'b0;

        // Reset clears previously written register
        wr(5'd5, 32'hDEADBEEF);
        rd(5'd5, 5'd5);
        check("r5_before_rst", a, 32'hDEADBEEF);
        check("r5_vld", {31'b0, a_vld}, 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_clears_a", a, 32'h0);
        check("rst_clears_vld", {31'b0, a_vld}, 32'h0);
        rd(5'd5, 5'd5);
        check("r5_after_rst", a, 32'h0);
        check("r5_after_rst_vld", {31'b0, a_vld}, 32'h1);
        step();
        check("vld_one_cycle", {31'b0, a_vld}, 32'h0);

        // Basic dual-port read
        wr(5'd1, 32'hAAAAAAAA);
        wr(5'd2, 32'h55555555);
        rd(5'd1, 5'd2);
        check("basic_a", a, 32'hAAAAAAAA);
        check("basic_b", b, 32'h55555555);
        rd(5'd2, 5'd2);
        check("same_addr_a", a, 32'h55555555);
        check("same_addr_b", b, 32'h55555555);

        // Zero register
        wr(5'd0, 32'hFFFFFFFF);
        rd(5'd0, 5'd0);
        check("r0_a", a, 32'h0);
        check("r0_b", b, 32'h0);

        // Same-edge write/read hazard
        wr(5'd3, 32'h00000010);
`ifdef MIPS_REGFILE_BYPASS_EN
        hazard_exp = 32'h00000001;
`else
        hazard_exp = 32'h00000010;
`endif
        we      = 1'b1;
        wa_addr = 5'd3;
        wd      = 32'h00000001;
        rd_en   = 1'b1;
        ra_addr = 5'd3;
        rb_addr = 5'd1;
        step();
        we      = 1'b0;
        rd_en   = 1'b0;
        check("hazard_a", a, hazard_exp);
        check("hazard_b_other", b, 32'hAAAAAAAA);
        rd(5'd3, 5'd3);
        check("hazard_next_a", a, 32'h00000001);
        check("hazard_next_b", b, 32'h00000001);

        // Same-edge write to r0 with read of r0: never forwarded
        we      = 1'b1;
        wa_addr = 5'd0;
        wd      = 32'hFFFFFFFF;
        rd_en   = 1'b1;
        ra_addr = 5'd0;
        rb_addr = 5'd0;
        step();
        we      = 1'b0;
        rd_en   = 1'b0;
        check("r0_bypass_a", a, 32'h0);
        check("r0_bypass_b", b, 32'h0);

        // Hold with rd_en low, then reset priority over write and read
        rd(5'd1, 5'd2);
        for (int i = 0; i < 3; i++) begin
            wr(5'd1, 32'h0BADF00D);
            check("hold_a", a, 32'hAAAAAAAA);
            check("hold_b", b, 32'h55555555);
            check("hold_vld", {31'b0, a_vld}, 32'h0);
        end
        rd(5'd1, 5'd1);
        check("write_while_held", a, 32'h0BADF00D);
        rst     = 1'b1;
        we      = 1'b1;
        wa_addr = 5'd4;
        wd      = 32'h12345678;
        rd_en   = 1'b1;
        ra_addr = 5'd4;
        rb_addr = 5'd1;
        step();
        rst   = 1'b0;
        we    = 1'b0;
        rd_en = 1'b0;
        check("prio_a", a, 32'h0);
        check("prio_vld", {31'b0, a_vld}, 32'h0);
        rd(5'd4, 5'd1);
        check("prio_r4", a, 32'h0);
        check("prio_r1_cleared", b, 32'h0);

        // Sweep all registers
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'(i) * 32'h01010101);
        end
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            check("sweep_a", a, 32'(i) * 32'h01010101);
            check("sweep_b", b, 32'(31 - i) * 32'h01010101);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
        $finish;
    end

endmodule
